// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered-read or first-word-fall-through output,
// programmable almost-full/almost-empty thresholds, sticky error flags and synchronous flush.
module sync_fifo_param #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 8,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 2,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] CNT_AE   = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             push_ok, pop_ok, mem_we;

  // Explicit wrap so any DEPTH works, not just powers of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop_ok      = pop & (count_q != '0);
    push_ok     = push & ((count_q != CNT_FULL) | pop_ok);
    mem_we      = push_ok & ~flush;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q | (push & ~push_ok);
      underflow_d = underflow_q | (pop & ~pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    end else begin : g_reg_read
      logic [DATA_W-1:0] data_out_q;
      // When full with a simultaneous push, wr_ptr == rd_ptr: the read sees the old head.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         data_out_q <= '0;
        else if (flush)  data_out_q <= '0;
        else if (pop_ok) data_out_q <= mem_q[rd_ptr_q];
      end
      assign data_out = data_out_q;
    end
  endgenerate

  assign count        = count_q;
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: registered-read FIFO (DEPTH=8) and FWFT FIFO (DEPTH=6) driven side by side.
module tb_sync_fifo_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: DEPTH=8, FWFT=0
  logic       a_flush, a_push, a_pop;
  logic [7:0] a_din, a_dout;
  logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
  logic [3:0] a_count;

  // Instance B: DEPTH=6, FWFT=1
  logic       b_flush, b_push, b_pop;
  logic [7:0] b_din, b_dout;
  logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
  logic [2:0] b_count;

  int checks = 0;
  int errors = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(8), .FWFT(0), .AF_LEVEL(6), .AE_LEVEL(2)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .push(a_push), .data_in(a_din), .pop(a_pop),
    .data_out(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
    .almost_empty(a_ae), .count(a_count), .overflow(a_ovf), .underflow(a_unf)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(6), .FWFT(1), .AF_LEVEL(5), .AE_LEVEL(1)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .push(b_push), .data_in(b_din), .pop(b_pop),
    .data_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
    .almost_empty(b_ae), .count(b_count), .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_flush = 0; a_push = 0; a_pop = 0; a_din = 0;
    b_flush = 0; b_push = 0; b_pop = 0; b_din = 0;
    cyc(); cyc();

    chk("rst_a_count", 32'(a_count), 0);
    chk("rst_a_empty", 32'(a_empty), 1);
    chk("rst_a_full",  32'(a_full), 0);
    chk("rst_a_ae",    32'(a_ae), 1);
    chk("rst_a_af",    32'(a_af), 0);
    chk("rst_a_dout",  32'(a_dout), 0);
    chk("rst_a_ovf",   32'(a_ovf), 0);
    chk("rst_a_unf",   32'(a_unf), 0);
    chk("rst_b_empty", 32'(b_empty), 1);
    chk("rst_b_dout",  32'(b_dout), 0);
    rst = 1'b0;
    cyc();

    // 1: push 1..9, ninth rejected
    for (int i = 1; i <= 9; i++) begin
      a_push = 1; a_din = 8'(i);
      cyc();
      chk($sformatf("t1_count_%0d", i), 32'(a_count), (i <= 8) ? i : 8);
      chk($sformatf("t1_af_%0d", i), 32'(a_af), (i >= 6) ? 1 : 0);
      $display("t1 push %0d count=%0d full=%0b ovf=%0b", i, a_count, a_full, a_ovf);
    end
    a_push = 0;
    chk("t1_full", 32'(a_full), 1);
    chk("t1_ovf",  32'(a_ovf), 1);

    // 2: pop 3, push 9/10 across the wrap, drain 4..10
    for (int i = 1; i <= 3; i++) begin
      a_pop = 1;
      cyc();
      chk($sformatf("t2_pop_dout_%0d", i), 32'(a_dout), i);
      $display("t2 pop dout=%0d count=%0d", a_dout, a_count);
    end
    a_pop = 0;
    chk("t2_count5", 32'(a_count), 5);
    chk("t2_notfull", 32'(a_full), 0);
    for (int i = 9; i <= 10; i++) begin
      a_push = 1; a_din = 8'(i);
      cyc();
      $display("t2 push %0d count=%0d", i, a_count);
    end
    a_push = 0;
    chk("t2_count7", 32'(a_count), 7);
    for (int i = 4; i <= 10; i++) begin
      a_pop = 1;
      cyc();
      chk($sformatf("t2_drain_%0d", i), 32'(a_dout), i);
      $display("t2 drain dout=%0d count=%0d", a_dout, a_count);
    end
    a_pop = 0;
    chk("t2_empty", 32'(a_empty), 1);

    // 3: fill to 5 with 11..15, then push 20..24 while popping
    for (int i = 11; i <= 15; i++) begin
      a_push = 1; a_din = 8'(i);
      cyc();
    end
    a_push = 0;
    chk("t3_count5", 32'(a_count), 5);
    for (int i = 0; i < 5; i++) begin
      a_push = 1; a_pop = 1; a_din = 8'(20 + i);
      cyc();
      chk($sformatf("t3_pp_count_%0d", i), 32'(a_count), 5);
      chk($sformatf("t3_pp_dout_%0d", i), 32'(a_dout), 11 + i);
      $display("t3 push %0d pop dout=%0d count=%0d", 20 + i, a_dout, a_count);
    end
    a_push = 0; a_pop = 0;
    chk("t3_af", 32'(a_af), 0);
    chk("t3_ae", 32'(a_ae), 0);
    chk("t3_ovf_sticky", 32'(a_ovf), 1);
    chk("t3_unf", 32'(a_unf), 0);
    for (int i = 0; i < 5; i++) begin
      a_pop = 1;
      cyc();
      chk($sformatf("t3_drain_%0d", i), 32'(a_dout), 20 + i);
      $display("t3 drain dout=%0d count=%0d", a_dout, a_count);
    end
    a_pop = 0;

    // 4: FWFT instance, DEPTH=6
    chk("t4_empty_dout", 32'(b_dout), 0);
    for (int i = 0; i < 6; i++) begin
      b_push = 1; b_din = 8'(8'hA0 + i);
      cyc();
      chk($sformatf("t4_head_%0d", i), 32'(b_dout), 32'hA0);
      $display("t4 push %0h count=%0d dout=%0h", 8'hA0 + i, b_count, b_dout);
    end
    b_push = 0;
    chk("t4_full", 32'(b_full), 1);
    chk("t4_af", 32'(b_af), 1);
    for (int i = 0; i < 4; i++) begin
      b_pop = 1;
      cyc();
      chk($sformatf("t4_pop_%0d", i), 32'(b_dout), 32'hA1 + i);
      $display("t4 pop dout=%0h count=%0d", b_dout, b_count);
    end
    b_pop = 0;
    chk("t4_count2", 32'(b_count), 2);
    for (int i = 0; i < 4; i++) begin
      b_push = 1; b_din = 8'(8'hB0 + i);
      cyc();
    end
    b_push = 0;
    chk("t4_full2", 32'(b_full), 1);
    begin
      logic [7:0] exp_b [6];
      exp_b = '{8'hA4, 8'hA5, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
      for (int i = 0; i < 6; i++) begin
        chk($sformatf("t4_drain_%0d", i), 32'(b_dout), 32'(exp_b[i]));
        $display("t4 drain dout=%0h count=%0d", b_dout, b_count);
        b_pop = 1;
        cyc();
      end
    end
    b_pop = 0;
    chk("t4_empty", 32'(b_empty), 1);
    chk("t4_empty_dout2", 32'(b_dout), 0);
    chk("t4_unf", 32'(b_unf), 0);

    // 5: flush A, then underflow on empty
    a_flush = 1;
    cyc();
    a_flush = 0;
    chk("t5_flush_ovf", 32'(a_ovf), 0);
    chk("t5_flush_dout", 32'(a_dout), 0);
    a_pop = 1;
    cyc();
    a_pop = 0;
    chk("t5_unf", 32'(a_unf), 1);
    chk("t5_count0", 32'(a_count), 0);
    chk("t5_dout_hold", 32'(a_dout), 0);
    $display("t5 pop empty unf=%0b count=%0d", a_unf, a_count);
    a_push = 1; a_pop = 1; a_din = 8'h55;
    cyc();
    a_push = 0; a_pop = 0;
    chk("t5_pp_count", 32'(a_count), 1);
    chk("t5_pp_unf", 32'(a_unf), 1);
    chk("t5_pp_dout", 32'(a_dout), 0);
    $display("t5 push+pop empty count=%0d unf=%0b", a_count, a_unf);

    // 6: fill, overflow, pop to 4, flush with push held
    for (int i = 0; i < 8; i++) begin
      a_push = 1; a_din = 8'(8'h30 + i);
      cyc();
    end
    a_push = 0;
    chk("t6_ovf", 32'(a_ovf), 1);
    begin
      logic [7:0] exp_a [4];
      exp_a = '{8'h55, 8'h30, 8'h31, 8'h32};
      for (int i = 0; i < 4; i++) begin
        a_pop = 1;
        cyc();
        chk($sformatf("t6_pop_%0d", i), 32'(a_dout), 32'(exp_a[i]));
      end
    end
    a_pop = 0;
    chk("t6_count4", 32'(a_count), 4);
    a_flush = 1; a_push = 1; a_din = 8'h77;
    cyc();
    a_flush = 0; a_push = 0;
    chk("t6_flush_count", 32'(a_count), 0);
    chk("t6_flush_empty", 32'(a_empty), 1);
    chk("t6_flush_ovf", 32'(a_ovf), 0);
    chk("t6_flush_unf", 32'(a_unf), 0);
    $display("t6 flush count=%0d empty=%0b ovf=%0b", a_count, a_empty, a_ovf);

    // Async reset in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      a_push = 1; a_din = 8'(8'h40 + i);
      cyc();
    end
    a_push = 0; a_pop = 1;
    cyc();
    a_pop = 0; a_push = 1; a_din = 8'h99;
    chk("t6_pre_rst_dout", 32'(a_dout), 32'h40);
    chk("t6_pre_rst_count", 32'(a_count), 2);
    rst = 1'b1;
    #1;
    chk("t6_rst_count", 32'(a_count), 0);
    chk("t6_rst_dout", 32'(a_dout), 0);
    chk("t6_rst_empty", 32'(a_empty), 1);
    $display("t6 async rst count=%0d dout=%0h", a_count, a_dout);
    cyc();
    rst = 1'b0;
    a_push = 0;
    chk("t6_rst_hold_count", 32'(a_count), 0);
    cyc();
    chk("t6_after_rst_count", 32'(a_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
